addr_stream_issuer: RTL and testbench

ADDR_STREAM_ISSUER -- requirements
Module: addr_stream_issuer

---
 rtl/addr_stream_issuer.sv | 148 ++++++++++++++
 tb/tb_addr_stream_issuer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/addr_stream_issuer.sv
// addr_stream_issuer
//   Pulls a burst of total_count addresses from an upstream nested address
//   generator (one per step strobe) and queues them in a small FIFO that
//   feeds a valid/ready memory request port.
//
//   Ports
//     clk          clock, rising edge
//     rst          synchronous active-high reset
//     start        begin a burst (honoured only in IDLE)
//     total_count  burst length, sampled when start is honoured
//     addr_in      current address from the upstream generator
//     step         advance strobe to the upstream generator
//     req_valid    request available at the FIFO head
//     req_addr     address at the FIFO head (0 when empty)
//     req_ready    downstream accepts the head request
//     busy         high while in RUN or DRAIN
//     done         one-cycle pulse when a burst completes
//
//   Optional feature (macro ADDR_STREAM_ISSUER_BOUNDS_EN):
//     addr_limit   input, any pushed address >= addr_limit is flagged
//     oob_err      sticky flag, cleared by rst or the next honoured start
module addr_stream_issuer #(
   parameter int ADDR_W     = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] total_count,
   input  logic [ADDR_W-1:0] addr_in,
   output logic              step,
   output logic              req_valid,
   output logic [ADDR_W-1:0] req_addr,
   input  logic              req_ready,
`ifdef ADDR_STREAM_ISSUER_BOUNDS_EN
   input  logic [ADDR_W-1:0] addr_limit,
   output logic              oob_err,
`endif
   output logic              busy,
   output logic              done
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   logic [1:0]        state;
   logic [ADDR_W-1:0] remaining;
   logic              done_q;   // zero-length burst completion, one cycle late

   logic [ADDR_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic              fifo_empty;
   logic              fifo_full;
   logic              push;
   logic              pop;

   // Occupancy is tracked by an explicit count so full and empty never
   // depend on pointer equality.
   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
   assign pop        = !fifo_empty && req_ready;

   // A full FIFO can still take a push when the head leaves this cycle.
   assign step = (state == S_RUN) && (remaining != '0) && (!fifo_full || pop);
   assign push = step;

   assign req_valid = !fifo_empty;
   assign req_addr  = fifo_empty ? '0 : mem[rd_ptr];
   assign busy      = (state != S_IDLE);
   assign done      = done_q || ((state == S_DRAIN) && fifo_empty);

   // Control FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         remaining <= '0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  if (total_count != '0) begin
                     remaining <= total_count;
                     state     <= S_RUN;
                  end else begin
                     done_q <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               if (step) begin
                  remaining <= remaining - ADDR_W'(1);
                  if (remaining == ADDR_W'(1))
                     state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (fifo_empty)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // FIFO bookkeeping; storage itself needs no reset since req_addr is
   // masked to zero while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= addr_in;
   end

`ifdef ADDR_STREAM_ISSUER_BOUNDS_EN
   // Out-of-range addresses are still queued; only the flag records them.
   always_ff @(posedge clk) begin
      if (rst)
         oob_err <= 1'b0;
      else if ((state == S_IDLE) && start)
         oob_err <= 1'b0;
      else if (push && (addr_in >= addr_limit))
         oob_err <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_addr_stream_issuer.sv
module tb_addr_stream_issuer;

   localparam int AW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AW-1:0] total_count;
   logic [AW-1:0] addr_in;
   logic          step;
   logic          req_valid;
   logic [AW-1:0] req_addr;
   logic          req_ready;
   logic          busy;
   logic          done;
`ifdef ADDR_STREAM_ISSUER_BOUNDS_EN
   logic [AW-1:0] addr_limit;
   logic          oob_err;
`endif

   addr_stream_issuer #(.ADDR_W(AW), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .start(start), .total_count(total_count),
      .addr_in(addr_in), .step(step), .req_valid(req_valid),
      .req_addr(req_addr), .req_ready(req_ready),
`ifdef ADDR_STREAM_ISSUER_BOUNDS_EN
      .addr_limit(addr_limit), .oob_err(oob_err),
`endif
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // upstream generator model and observation state
   logic [AW-1:0] seq [16];
   logic [AW-1:0] got [$];
   int gi, steps, dones, occ, max_occ, cyc, done_cyc, run_len, max_run, busy_seen;

   task automatic clear_obs();
      got.delete();
      gi = 0; steps = 0; dones = 0; occ = 0; max_occ = 0; cyc = 0;
      done_cyc = -1; run_len = 0; max_run = 0; busy_seen = 0;
      addr_in = seq[0];
   endtask

   // Sample one cycle's outputs, clock it, then present the next generator value.
   task automatic clk_cycle();
      logic st, pp;
      #1;
      st = step;
      pp = req_valid && req_ready;
      if (st) begin steps++; run_len++; if (run_len > max_run) max_run = run_len; end
      else run_len = 0;
      if (pp) got.push_back(req_addr);
      if (done) begin dones++; if (done_cyc < 0) done_cyc = cyc; end
      if (busy) busy_seen = 1;
      occ = occ + (st ? 1 : 0) - (pp ? 1 : 0);
      if (occ > max_occ) max_occ = occ;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (st) gi++;
      addr_in = seq[gi % 16];
      cyc++;
   endtask

   task automatic check_stream(input string name, input int n);
      checks++;
      if (got.size() != n) begin
         failures++;
         $display("FAIL %s count: got %0d required %0d", name, got.size(), n);
      end else begin
         for (int i = 0; i < n; i++) begin
            checks++;
            if (got[i] !== seq[i]) begin
               failures++;
               $display("FAIL %s addr[%0d]: got %0d required %0d", name, i, got[i], seq[i]);
            end
         end
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      start = 1'b0; total_count = '0; req_ready = 1'b1;
      for (int i = 0; i < 16; i++) seq[i] = AW'(i);
      addr_in = '0;
`ifdef ADDR_STREAM_ISSUER_BOUNDS_EN
      addr_limit = '1;
`endif
      rst = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++; if (step !== 1'b0)      begin failures++; $display("FAIL reset_step: got %b required 0", step); end
      checks++; if (req_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b required 0", req_valid); end
      checks++; if (req_addr !== '0)    begin failures++; $display("FAIL reset_addr: got %0d required 0", req_addr); end
      checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL reset_busy: got %b required 0", busy); end
      checks++; if (done !== 1'b0)      begin failures++; $display("FAIL reset_done: got %b required 0", done); end
`ifdef ADDR_STREAM_ISSUER_BOUNDS_EN
      checks++; if (oob_err !== 1'b0)   begin failures++; $display("FAIL reset_oob: got %b required 0", oob_err); end
`endif
      rst = 1'b0;
   endtask

   // count=6, ready=1, addresses 0,2,4,0,2,4
   task automatic test_stream();
      seq[0] = 0; seq[1] = 2; seq[2] = 4; seq[3] = 0; seq[4] = 2; seq[5] = 4;
      req_ready = 1'b1;
      clear_obs();
      start = 1'b1; total_count = 16'd6;
      for (int i = 0; i < 14; i++) clk_cycle();
      checks++; if (steps != 6)   begin failures++; $display("FAIL stream_steps: got %0d required 6", steps); end
      checks++; if (max_run != 6) begin failures++; $display("FAIL stream_consecutive: got %0d required 6", max_run); end
      check_stream("stream", 6);
      checks++; if (dones != 1)   begin failures++; $display("FAIL stream_dones: got %0d required 1", dones); end
      // start at cycle 0, pushes in 1..6, last pop in 7, empty DRAIN in 8
      checks++; if (done_cyc != 8) begin failures++; $display("FAIL stream_done_cycle: got %0d required 8", done_cyc); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL stream_idle_busy: got %b required 0", busy); end
   endtask

   // count=10 with a stalled consumer
   task automatic test_backpressure();
      for (int i = 0; i < 16; i++) seq[i] = AW'(3 * i + 1);
      req_ready = 1'b0;
      clear_obs();
      start = 1'b1; total_count = 16'd10;
      for (int i = 0; i < 8; i++) clk_cycle();
      #1;
      checks++; if (steps != 4)        begin failures++; $display("FAIL bp_steps: got %0d required 4", steps); end
      checks++; if (step !== 1'b0)     begin failures++; $display("FAIL bp_step_held: got %b required 0", step); end
      checks++; if (req_valid !== 1'b1) begin failures++; $display("FAIL bp_valid: got %b required 1", req_valid); end
      checks++; if (req_addr !== seq[0]) begin failures++; $display("FAIL bp_addr_stable: got %0d required %0d", req_addr, seq[0]); end
      checks++; if (max_occ > 4)       begin failures++; $display("FAIL bp_occupancy: got %0d required <=4", max_occ); end
      req_ready = 1'b1;
      for (int i = 0; i < 20; i++) clk_cycle();
      check_stream("bp", 10);
      checks++; if (dones != 1)  begin failures++; $display("FAIL bp_dones: got %0d required 1", dones); end
      checks++; if (steps != 10) begin failures++; $display("FAIL bp_total_steps: got %0d required 10", steps); end
   endtask

   // zero-length burst
   task automatic test_zero_count();
      req_ready = 1'b1;
      clear_obs();
      start = 1'b1; total_count = 16'd0;
      for (int i = 0; i < 5; i++) clk_cycle();
      checks++; if (done_cyc != 1) begin failures++; $display("FAIL zero_done_cycle: got %0d required 1", done_cyc); end
      checks++; if (dones != 1)    begin failures++; $display("FAIL zero_dones: got %0d required 1", dones); end
      checks++; if (steps != 0)    begin failures++; $display("FAIL zero_steps: got %0d required 0", steps); end
      checks++; if (busy_seen != 0) begin failures++; $display("FAIL zero_busy: got %0d required 0", busy_seen); end
   endtask

   // reset in the middle of an 8-address burst
   task automatic test_reset_mid_burst();
      for (int i = 0; i < 16; i++) seq[i] = AW'(100 + i);
      req_ready = 1'b0;
      clear_obs();
      start = 1'b1; total_count = 16'd8;
      for (int i = 0; i < 4; i++) clk_cycle();
      checks++; if (steps != 3) begin failures++; $display("FAIL rstmid_steps: got %0d required 3", steps); end
      rst = 1'b1;
      clk_cycle();
      rst = 1'b0;
      #1;
      checks++; if (req_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid: got %b required 0", req_valid); end
      checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL rstmid_idle: got %b required 0", busy); end
      checks++; if (step !== 1'b0)      begin failures++; $display("FAIL rstmid_step: got %b required 0", step); end
      req_ready = 1'b1;
      dones = 0;
      got.delete();
      for (int i = 0; i < 10; i++) clk_cycle();
      checks++; if (dones != 0)      begin failures++; $display("FAIL rstmid_dones: got %0d required 0", dones); end
      checks++; if (got.size() != 0) begin failures++; $display("FAIL rstmid_pops: got %0d required 0", got.size()); end
   endtask

   // full FIFO, consumer ready on alternate cycles
   task automatic test_back_to_back();
      int missed;
      for (int i = 0; i < 16; i++) seq[i] = AW'(16'h200 + 5 * i);
      req_ready = 1'b0;
      clear_obs();
      missed = 0;
      start = 1'b1; total_count = 16'd12;
      for (int i = 0; i < 6; i++) clk_cycle();
      checks++; if (occ != 4) begin failures++; $display("FAIL b2b_fill: got %0d required 4", occ); end
      for (int i = 0; i < 40; i++) begin
         req_ready = ~req_ready;
         #1;
         if (occ == 4 && req_ready && steps < 12 && step !== 1'b1) missed++;
         clk_cycle();
      end
      checks++; if (missed != 0)  begin failures++; $display("FAIL b2b_push_on_pop: got %0d missed required 0", missed); end
      checks++; if (max_occ > 4)  begin failures++; $display("FAIL b2b_occupancy: got %0d required <=4", max_occ); end
      check_stream("b2b", 12);
      checks++; if (dones != 1)   begin failures++; $display("FAIL b2b_dones: got %0d required 1", dones); end
   endtask

`ifdef ADDR_STREAM_ISSUER_BOUNDS_EN
   task automatic test_bounds();
      seq[0] = 1; seq[1] = 7; seq[2] = 2;
      req_ready = 1'b1;
      addr_limit = 16'd5;
      clear_obs();
      start = 1'b1; total_count = 16'd3;
      for (int i = 0; i < 2; i++) clk_cycle();
      checks++; if (oob_err !== 1'b0) begin failures++; $display("FAIL oob_early: got %b required 0", oob_err); end
      for (int i = 0; i < 8; i++) clk_cycle();
      checks++; if (oob_err !== 1'b1) begin failures++; $display("FAIL oob_set: got %b required 1", oob_err); end
      check_stream("oob", 3);
      seq[0] = 1; seq[1] = 2;
      clear_obs();
      start = 1'b1; total_count = 16'd2;
      clk_cycle();
      checks++; if (oob_err !== 1'b0) begin failures++; $display("FAIL oob_clear: got %b required 0", oob_err); end
      for (int i = 0; i < 8; i++) clk_cycle();
   endtask
`endif

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_zero_count();
      test_reset_mid_burst();
      test_back_to_back();
`ifdef ADDR_STREAM_ISSUER_BOUNDS_EN
      do_reset();
      test_bounds();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
